// File: rtl/issue_queue_jmp_pkg.sv
// Shared definitions for the jump/branch issue queue: field widths, the
// queue entry layout and the operand source-select encoding used by the
// jump register-read stage.
package issue_queue_jmp_pkg;

    localparam int POS_W  = 6;   // ROB position
    localparam int PREG_W = 6;   // physical register tag
    localparam int AREG_W = 5;   // architectural register index
    localparam int PC_W   = 32;

    // Downstream operand mux select; bit 1 distinguishes JMP from ALU bypass.
    typedef enum logic [1:0] {
        SRC_PRS        = 2'b00,
        SRC_ALU_BYPASS = 2'b01,
        SRC_JMP_BYPASS = 2'b11
    } src_sel_e;

    // Static fields captured at dispatch; readiness lives in the wake cells.
    typedef struct packed {
        logic [POS_W-1:0]  pos;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic              prs1_valid;
        logic              prs2_valid;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [AREG_W-1:0] rs1;
        logic [AREG_W-1:0] rs2;
        logic [AREG_W-1:0] rd;
        logic [PC_W-1:0]   pc;
    } iq_jmp_entry_t;

endpackage

// File: rtl/iq_jmp_src_wake.sv
// Readiness tracker for one source operand of one queue entry. Compares the
// source tag against the ALU, JMP and writeback wake ports; while the entry
// is being written it compares the incoming dispatch tag instead, so a wake
// in the dispatch cycle is not lost. Fresh bits record "woken last cycle".
module iq_jmp_src_wake
    import issue_queue_jmp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic [PREG_W-1:0] disp_tag,
    input  logic              disp_used,
    input  logic              disp_busy_ready,
    input  logic [PREG_W-1:0] held_tag,
    input  logic              held_used,
    input  logic              alu_wake_valid,
    input  logic [PREG_W-1:0] alu_wake_tag,
    input  logic              jmp_wake_valid,
    input  logic [PREG_W-1:0] jmp_wake_tag,
    input  logic              wb_wake_valid,
    input  logic [PREG_W-1:0] wb_wake_tag,
    output logic              rdy,
    output logic              alufresh,
    output logic              jmpfresh
);

    logic [PREG_W-1:0] tag;
    logic              used;
    logic              alu_hit;
    logic              jmp_hit;
    logic              wb_hit;

    // Select the tag being tracked this cycle and match it against the wake ports.
    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        tag     = load ? disp_tag  : held_tag;
        used    = load ? disp_used : held_used;
        alu_hit = used && (tag != '0) && alu_wake_valid && (alu_wake_tag == tag);
        jmp_hit = used && (tag != '0) && jmp_wake_valid && (jmp_wake_tag == tag);
        wb_hit  = used && (tag != '0) && wb_wake_valid  && (wb_wake_tag  == tag);
    end

    // Ready is sticky until the slot is rewritten; fresh bits last one cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdy      <= 1'b0;
            alufresh <= 1'b0;
            jmpfresh <= 1'b0;
        end else begin
            rdy      <= (load ? (!disp_used || disp_busy_ready) : rdy)
                        || alu_hit || jmp_hit || wb_hit;
            alufresh <= alu_hit;
            jmpfresh <= jmp_hit;
        end
    end

endmodule

// File: rtl/issue_queue_jmp.sv
// In-order issue queue for the jump/branch pipe. A circular buffer of
// dispatched micro-ops; the head issues once both of its sources are ready,
// carrying ALU/JMP bypass flags. Younger entries never pass the head.
module issue_queue_jmp
    import issue_queue_jmp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_iq,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [POS_W-1:0]  disp_pos,
    input  logic [PREG_W-1:0] disp_prd,
    input  logic [PREG_W-1:0] disp_prs1,
    input  logic [PREG_W-1:0] disp_prs2,
    input  logic              disp_prs1_valid,
    input  logic              disp_prs2_valid,
    input  logic              disp_prs1_ready,
    input  logic              disp_prs2_ready,
    input  logic [2:0]        disp_funct3,
    input  logic [6:0]        disp_funct7,
    input  logic [AREG_W-1:0] disp_rs1,
    input  logic [AREG_W-1:0] disp_rs2,
    input  logic [AREG_W-1:0] disp_rd,
    input  logic [PC_W-1:0]   disp_pc,
    input  logic              alu_wake_valid,
    input  logic [PREG_W-1:0] alu_wake_tag,
    input  logic              jmp_wake_valid,
    input  logic [PREG_W-1:0] jmp_wake_tag,
    input  logic              wb_wake_valid,
    input  logic [PREG_W-1:0] wb_wake_tag,
    output logic              req_issue,
    output logic [POS_W-1:0]  pos_issue,
    output logic [PREG_W-1:0] prd_issue,
    output logic [PREG_W-1:0] prs1_issue,
    output logic [PREG_W-1:0] prs2_issue,
    output logic              prs1_valid_issue,
    output logic              prs2_valid_issue,
    output logic [2:0]        funct3_issue,
    output logic [6:0]        funct7_issue,
    output logic [AREG_W-1:0] rs1_issue,
    output logic [AREG_W-1:0] rs2_issue,
    output logic [AREG_W-1:0] rd_issue,
    output logic [PC_W-1:0]   pc_issue,
    output logic              alubypass1_issue,
    output logic              alubypass2_issue,
    output logic              jmpbypass1_issue,
    output logic              jmpbypass2_issue
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    iq_jmp_entry_t      mem [DEPTH];
    iq_jmp_entry_t      head_ent;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;
    logic [DEPTH-1:0]   rdy1, rdy2, alufresh1, alufresh2, jmpfresh1, jmpfresh2;
    logic               do_disp;
    logic               do_issue;

    // Handshake and issue decision from registered state only.
    always_comb begin
        disp_ready = !reset && !flush_iq && (count < FULL_COUNT);
        do_disp    = disp_valid && disp_ready;
        head_ent   = mem[head];
        req_issue  = !reset && !flush_iq && (count != '0) && rdy1[head] && rdy2[head];
        do_issue   = req_issue;
    end

    // Issue fields come straight from the head slot; bypass flags are gated by issue.
    always_comb begin
        pos_issue        = head_ent.pos;
        prd_issue        = head_ent.prd;
        prs1_issue       = head_ent.prs1;
        prs2_issue       = head_ent.prs2;
        prs1_valid_issue = head_ent.prs1_valid;
        prs2_valid_issue = head_ent.prs2_valid;
        funct3_issue     = head_ent.funct3;
        funct7_issue     = head_ent.funct7;
        rs1_issue        = head_ent.rs1;
        rs2_issue        = head_ent.rs2;
        rd_issue         = head_ent.rd;
        pc_issue         = head_ent.pc;
        alubypass1_issue = req_issue && alufresh1[head];
        alubypass2_issue = req_issue && alufresh2[head];
        jmpbypass1_issue = req_issue && jmpfresh1[head] && !alufresh1[head];
        jmpbypass2_issue = req_issue && jmpfresh2[head] && !alufresh2[head];
    end

    // Pointer and occupancy bookkeeping; flush wins over issue and dispatch.
    always_ff @(posedge clk) begin
        if (reset || flush_iq) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_issue) head <= head + PTR_W'(1);
            if (do_disp)  tail <= tail + PTR_W'(1);
            case ({do_disp, do_issue})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Field storage written at the tail.
    // NOTE: payload storage has no reset; occupancy and readiness decide whether a slot is live.
    always_ff @(posedge clk) begin
        if (do_disp) begin
            mem[tail] <= '{pos: disp_pos, prd: disp_prd, prs1: disp_prs1, prs2: disp_prs2,
                           prs1_valid: disp_prs1_valid, prs2_valid: disp_prs2_valid,
                           funct3: disp_funct3, funct7: disp_funct7, rs1: disp_rs1,
                           rs2: disp_rs2, rd: disp_rd, pc: disp_pc};
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic load;
        assign load = do_disp && (tail == PTR_W'(i));

        iq_jmp_src_wake u_src1 (
            .clk(clk), .reset(reset), .flush(flush_iq), .load(load),
            .disp_tag(disp_prs1), .disp_used(disp_prs1_valid), .disp_busy_ready(disp_prs1_ready),
            .held_tag(mem[i].prs1), .held_used(mem[i].prs1_valid),
            .alu_wake_valid(alu_wake_valid), .alu_wake_tag(alu_wake_tag),
            .jmp_wake_valid(jmp_wake_valid), .jmp_wake_tag(jmp_wake_tag),
            .wb_wake_valid(wb_wake_valid), .wb_wake_tag(wb_wake_tag),
            .rdy(rdy1[i]), .alufresh(alufresh1[i]), .jmpfresh(jmpfresh1[i])
        );

        iq_jmp_src_wake u_src2 (
            .clk(clk), .reset(reset), .flush(flush_iq), .load(load),
            .disp_tag(disp_prs2), .disp_used(disp_prs2_valid), .disp_busy_ready(disp_prs2_ready),
            .held_tag(mem[i].prs2), .held_used(mem[i].prs2_valid),
            .alu_wake_valid(alu_wake_valid), .alu_wake_tag(alu_wake_tag),
            .jmp_wake_valid(jmp_wake_valid), .jmp_wake_tag(jmp_wake_tag),
            .wb_wake_valid(wb_wake_valid), .wb_wake_tag(wb_wake_tag),
            .rdy(rdy2[i]), .alufresh(alufresh2[i]), .jmpfresh(jmpfresh2[i])
        );
    end

endmodule

// File: tb/tb_issue_queue_jmp.sv
// Self-checking bench for issue_queue_jmp: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_issue_queue_jmp;

    logic        clk = 1'b0;
    logic        reset, flush_iq, disp_valid, disp_ready;
    logic [5:0]  disp_pos, disp_prd, disp_prs1, disp_prs2;
    logic        disp_prs1_valid, disp_prs2_valid, disp_prs1_ready, disp_prs2_ready;
    logic [2:0]  disp_funct3;
    logic [6:0]  disp_funct7;
    logic [4:0]  disp_rs1, disp_rs2, disp_rd;
    logic [31:0] disp_pc;
    logic        alu_wake_valid, jmp_wake_valid, wb_wake_valid;
    logic [5:0]  alu_wake_tag, jmp_wake_tag, wb_wake_tag;
    logic        req_issue;
    logic [5:0]  pos_issue, prd_issue, prs1_issue, prs2_issue;
    logic        prs1_valid_issue, prs2_valid_issue;
    logic [2:0]  funct3_issue;
    logic [6:0]  funct7_issue;
    logic [4:0]  rs1_issue, rs2_issue, rd_issue;
    logic [31:0] pc_issue;
    logic        alubypass1_issue, alubypass2_issue, jmpbypass1_issue, jmpbypass2_issue;

    int tests_run    = 0;
    int tests_failed = 0;

    issue_queue_jmp dut (
        .clk(clk), .reset(reset), .flush_iq(flush_iq),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pos(disp_pos), .disp_prd(disp_prd), .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
        .disp_prs1_valid(disp_prs1_valid), .disp_prs2_valid(disp_prs2_valid),
        .disp_prs1_ready(disp_prs1_ready), .disp_prs2_ready(disp_prs2_ready),
        .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd), .disp_pc(disp_pc),
        .alu_wake_valid(alu_wake_valid), .alu_wake_tag(alu_wake_tag),
        .jmp_wake_valid(jmp_wake_valid), .jmp_wake_tag(jmp_wake_tag),
        .wb_wake_valid(wb_wake_valid), .wb_wake_tag(wb_wake_tag),
        .req_issue(req_issue), .pos_issue(pos_issue), .prd_issue(prd_issue),
        .prs1_issue(prs1_issue), .prs2_issue(prs2_issue),
        .prs1_valid_issue(prs1_valid_issue), .prs2_valid_issue(prs2_valid_issue),
        .funct3_issue(funct3_issue), .funct7_issue(funct7_issue),
        .rs1_issue(rs1_issue), .rs2_issue(rs2_issue), .rd_issue(rd_issue), .pc_issue(pc_issue),
        .alubypass1_issue(alubypass1_issue), .alubypass2_issue(alubypass2_issue),
        .jmpbypass1_issue(jmpbypass1_issue), .jmpbypass2_issue(jmpbypass2_issue)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] byp();
        return {alubypass1_issue, alubypass2_issue, jmpbypass1_issue, jmpbypass2_issue};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_iq = 0; disp_valid = 0;
        alu_wake_valid = 0; jmp_wake_valid = 0; wb_wake_valid = 0;
        alu_wake_tag = 0; jmp_wake_tag = 0; wb_wake_tag = 0;
    endtask

    task automatic set_disp(input logic [5:0] pos, input logic [5:0] prs1, input logic v1,
                            input logic r1, input logic [5:0] prs2, input logic v2,
                            input logic r2, input logic [31:0] pc);
        disp_valid = 1; disp_pos = pos; disp_prd = pos + 6'd20;
        disp_prs1 = prs1; disp_prs1_valid = v1; disp_prs1_ready = r1;
        disp_prs2 = prs2; disp_prs2_valid = v2; disp_prs2_ready = r2;
        disp_funct3 = pos[2:0]; disp_funct7 = {1'b0, pos}; disp_rs1 = 5'd1; disp_rs2 = 5'd2;
        disp_rd = pos[4:0]; disp_pc = pc;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        set_disp(6'd63, 6'd0, 0, 0, 6'd0, 0, 0, 32'h0);
        tick(); tick();
        tests_run++;
        if (req_issue !== 1'b0 || disp_ready !== 1'b0 || byp() !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req=%b ready=%b byp=%b, required 0 0 0000", req_issue, disp_ready, byp());
        end
        reset = 0; disp_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b0 || disp_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset: req=%b ready=%b, required 0 1 (dispatch during reset must be dropped)", req_issue, disp_ready);
        end
    endtask

    task automatic test_jal();
        set_disp(6'd1, 6'd0, 0, 0, 6'd0, 0, 0, 32'h100);
        tick(); disp_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b1 || pc_issue !== 32'h100 || pos_issue !== 6'd1 || byp() !== 4'b0) begin
            tests_failed++;
            $display("FAIL jal_issue: req=%b pc=%h pos=%0d byp=%b, required 1 00000100 1 0000", req_issue, pc_issue, pos_issue, byp());
        end
        tick();
        tests_run++;
        if (req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL jal_drained: req=%b, required 0", req_issue);
        end
    endtask

    task automatic test_alu_bypass();
        set_disp(6'd2, 6'd5, 1, 0, 6'd0, 1, 1, 32'h200);
        tick(); disp_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_wait: req=%b, required 0", req_issue);
        end
        alu_wake_valid = 1; alu_wake_tag = 6'd5;
        tests_run++;
        #1;
        if (req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_wake_same_cycle: req=%b, required 0", req_issue);
        end
        tick(); alu_wake_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b1 || pos_issue !== 6'd2 || byp() !== 4'b1000) begin
            tests_failed++;
            $display("FAIL alu_bypass: req=%b pos=%0d byp=%b, required 1 2 1000", req_issue, pos_issue, byp());
        end
        tick();
        // Second op held one extra cycle by a writeback-woken second source.
        set_disp(6'd4, 6'd5, 1, 0, 6'd6, 1, 0, 32'h204);
        tick(); disp_valid = 0;
        alu_wake_valid = 1; alu_wake_tag = 6'd5;
        tick(); alu_wake_valid = 0;
        wb_wake_valid = 1; wb_wake_tag = 6'd6; #1;
        tests_run++;
        if (req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_hold_wait: req=%b, required 0", req_issue);
        end
        tick(); wb_wake_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b1 || pos_issue !== 6'd4 || byp() !== 4'b0000) begin
            tests_failed++;
            $display("FAIL alu_stale: req=%b pos=%0d byp=%b, required 1 4 0000", req_issue, pos_issue, byp());
        end
        tick();
    endtask

    task automatic test_jmp_same_cycle();
        set_disp(6'd3, 6'd7, 1, 0, 6'd0, 0, 0, 32'h300);
        jmp_wake_valid = 1; jmp_wake_tag = 6'd7;
        tick(); disp_valid = 0; jmp_wake_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b1 || pos_issue !== 6'd3 || byp() !== 4'b0010) begin
            tests_failed++;
            $display("FAIL jmp_dispatch_wake: req=%b pos=%0d byp=%b, required 1 3 0010", req_issue, pos_issue, byp());
        end
        tick();
    endtask

    task automatic test_tag_zero();
        set_disp(6'd30, 6'd0, 1, 0, 6'd0, 0, 0, 32'h400);
        alu_wake_valid = 1; alu_wake_tag = 6'd0;
        tick(); disp_valid = 0;
        wb_wake_valid = 1; wb_wake_tag = 6'd0;
        tick(); idle_inputs(); #1;
        tests_run++;
        if (req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL tag_zero_ignored: req=%b, required 0", req_issue);
        end
        flush_iq = 1; tick(); flush_iq = 0;
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 8; i++) begin
            set_disp(6'(i), (i == 0) ? 6'd9 : 6'd0, (i == 0), 0, 6'd0, 0, 0, 32'h1000 + 32'(i * 4));
            #1;
            tests_run++;
            if (disp_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL fill_ready_%0d: ready=%b, required 1", i, disp_ready);
            end
            tick();
        end
        set_disp(6'd8, 6'd0, 0, 0, 6'd0, 0, 0, 32'hdead); #1;
        tests_run++;
        if (disp_ready !== 1'b0 || req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL full: ready=%b req=%b, required 0 0", disp_ready, req_issue);
        end
        tick(); disp_valid = 0;
        wb_wake_valid = 1; wb_wake_tag = 6'd9;
        tick(); wb_wake_valid = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if (req_issue !== 1'b1 || pos_issue !== 6'(i) || pc_issue !== 32'h1000 + 32'(i * 4)
                || disp_ready !== (i != 0)) begin
                tests_failed++;
                $display("FAIL drain_%0d: req=%b pos=%0d pc=%h ready=%b, required 1 %0d %h %b",
                         i, req_issue, pos_issue, pc_issue, disp_ready, i, 32'h1000 + 32'(i * 4), i != 0);
            end
            tick();
        end
        #1;
        tests_run++;
        if (req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: req=%b, required 0 (refused op must be absent)", req_issue);
        end
    endtask

    task automatic test_in_order();
        set_disp(6'd10, 6'd9, 1, 0, 6'd0, 0, 0, 32'h500); tick();
        set_disp(6'd11, 6'd0, 0, 0, 6'd0, 0, 0, 32'h504); tick();
        set_disp(6'd12, 6'd0, 0, 0, 6'd0, 0, 0, 32'h508); tick();
        disp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req_issue !== 1'b0) begin
                tests_failed++;
                $display("FAIL in_order_block_%0d: req=%b pos=%0d, required 0", i, req_issue, pos_issue);
            end
            tick();
        end
        wb_wake_valid = 1; wb_wake_tag = 6'd9; tick(); wb_wake_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req_issue !== 1'b1 || pos_issue !== 6'(10 + i)) begin
                tests_failed++;
                $display("FAIL in_order_issue_%0d: req=%b pos=%0d, required 1 %0d", i, req_issue, pos_issue, 10 + i);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_disp(6'(32 + i), 6'd9, 1, 0, 6'd0, 0, 0, 32'h600 + 32'(i)); tick();
        end
        set_disp(6'd40, 6'd0, 0, 0, 6'd0, 0, 0, 32'h6ff);
        flush_iq = 1; alu_wake_valid = 1; alu_wake_tag = 6'd9; #1;
        tests_run++;
        if (req_issue !== 1'b0 || disp_ready !== 1'b0 || byp() !== 4'b0) begin
            tests_failed++;
            $display("FAIL flush_cycle: req=%b ready=%b byp=%b, required 0 0 0000", req_issue, disp_ready, byp());
        end
        tick(); idle_inputs();
        wb_wake_valid = 1; wb_wake_tag = 6'd9; #1;
        tests_run++;
        if (req_issue !== 1'b0 || disp_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_empty: req=%b ready=%b, required 0 1", req_issue, disp_ready);
        end
        tick(); wb_wake_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_gone: req=%b pos=%0d, required 0", req_issue, pos_issue);
        end
        set_disp(6'd41, 6'd0, 0, 0, 6'd0, 0, 0, 32'h700);
        tick(); disp_valid = 0; #1;
        tests_run++;
        if (req_issue !== 1'b1 || pos_issue !== 6'd41 || pc_issue !== 32'h700) begin
            tests_failed++;
            $display("FAIL flush_new: req=%b pos=%0d pc=%h, required 1 41 00000700", req_issue, pos_issue, pc_issue);
        end
        tick();
    endtask

    // Reference model: an ordered list of pending ops with per-source readiness.
    typedef struct {
        logic [5:0]  pos, prd, prs1, prs2;
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        v1, v2, r1, r2, a1, a2, j1, j2;
    } m_ent_t;
    m_ent_t mq[$];

    // Returns {alu, jmp, wb} matches of a used, nonzero tag against this cycle's wakes.
    function automatic logic [2:0] m_hits(input logic [5:0] tag, input logic used);
        logic ok;
        ok = used && (tag != 0);
        return {ok && alu_wake_valid && alu_wake_tag == tag,
                ok && jmp_wake_valid && jmp_wake_tag == tag,
                ok && wb_wake_valid  && wb_wake_tag  == tag};
    endfunction

    task automatic test_random();
        logic       exp_req, exp_rdy;
        logic [3:0] exp_byp;
        logic [2:0] h1, h2;
        m_ent_t     e;
        logic [5:0] seq = 0;
        idle_inputs(); flush_iq = 1; tick(); flush_iq = 0;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            flush_iq        = ($urandom_range(0, 39) == 0);
            disp_valid      = $urandom_range(0, 1);
            disp_pos        = seq; disp_prd = 6'($urandom);
            disp_prs1_valid = ($urandom_range(0, 9) < 7);
            disp_prs2_valid = ($urandom_range(0, 9) < 7);
            disp_prs1       = disp_prs1_valid ? 6'($urandom_range(1, 7)) : 6'd0;
            disp_prs2       = disp_prs2_valid ? 6'($urandom_range(1, 7)) : 6'd0;
            disp_prs1_ready = ($urandom_range(0, 9) < 4);
            disp_prs2_ready = ($urandom_range(0, 9) < 4);
            disp_funct3 = 3'($urandom); disp_funct7 = 7'($urandom);
            disp_rs1 = 5'($urandom); disp_rs2 = 5'($urandom); disp_rd = 5'($urandom);
            disp_pc = $urandom;
            alu_wake_valid = ($urandom_range(0, 9) < 3); alu_wake_tag = 6'($urandom_range(0, 7));
            jmp_wake_valid = ($urandom_range(0, 9) < 3); jmp_wake_tag = 6'($urandom_range(0, 7));
            wb_wake_valid  = ($urandom_range(0, 9) < 3); wb_wake_tag  = 6'($urandom_range(0, 7));
            #1;
            exp_rdy = !flush_iq && (mq.size() < 8);
            exp_req = !flush_iq && (mq.size() > 0) && mq[0].r1 && mq[0].r2;
            exp_byp = exp_req ? {mq[0].a1, mq[0].a2, mq[0].j1 && !mq[0].a1, mq[0].j2 && !mq[0].a2} : 4'b0;
            tests_run++;
            if (req_issue !== exp_req || disp_ready !== exp_rdy || byp() !== exp_byp) begin
                tests_failed++;
                $display("FAIL rand_ctl_%0d: req=%b ready=%b byp=%b, required %b %b %b",
                         c, req_issue, disp_ready, byp(), exp_req, exp_rdy, exp_byp);
            end
            if (exp_req) begin
                tests_run++;
                if (pos_issue !== mq[0].pos || prd_issue !== mq[0].prd || pc_issue !== mq[0].pc
                    || funct3_issue !== mq[0].f3 || rd_issue !== mq[0].rd || prs1_issue !== mq[0].prs1) begin
                    tests_failed++;
                    $display("FAIL rand_fields_%0d: pos=%0d prd=%0d pc=%h, required %0d %0d %h",
                             c, pos_issue, prd_issue, pc_issue, mq[0].pos, mq[0].prd, mq[0].pc);
                end
            end
            if (flush_iq) begin
                mq.delete();
            end else begin
                foreach (mq[k]) begin
                    h1 = m_hits(mq[k].prs1, mq[k].v1);
                    h2 = m_hits(mq[k].prs2, mq[k].v2);
                    mq[k].r1 = mq[k].r1 || (|h1); mq[k].a1 = h1[2]; mq[k].j1 = h1[1];
                    mq[k].r2 = mq[k].r2 || (|h2); mq[k].a2 = h2[2]; mq[k].j2 = h2[1];
                end
                if (exp_req) void'(mq.pop_front());
                if (disp_valid && exp_rdy) begin
                    h1 = m_hits(disp_prs1, disp_prs1_valid);
                    h2 = m_hits(disp_prs2, disp_prs2_valid);
                    e.pos = disp_pos; e.prd = disp_prd; e.prs1 = disp_prs1; e.prs2 = disp_prs2;
                    e.pc = disp_pc; e.f3 = disp_funct3; e.rd = disp_rd;
                    e.v1 = disp_prs1_valid; e.v2 = disp_prs2_valid;
                    e.r1 = !disp_prs1_valid || disp_prs1_ready || (|h1);
                    e.r2 = !disp_prs2_valid || disp_prs2_ready || (|h2);
                    e.a1 = h1[2]; e.j1 = h1[1]; e.a2 = h2[2]; e.j2 = h2[1];
                    mq.push_back(e);
                    seq++;
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_jal();
        test_alu_bypass();
        test_jmp_same_cycle();
        test_tag_zero();
        test_fill_wrap();
        test_in_order();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
